// File: rtl/scan_ctrl4.sv
`default_nettype none
// ============================================================================
// Module   : scan_ctrl4
// Brief    : Four-digit time-multiplexed scan controller with frame-latched
//            shadow buffer and blanking gap ahead of every digit.
// Revision : 1.0 - initial release
// ============================================================================
module scan_ctrl4 #(
    parameter int DIV    = 4,
    parameter int BLANK  = 1,
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [4*DATA_W-1:0]   digits,
    output logic                  a,
    output logic                  b,
    output logic                  en,
    output logic [DATA_W-1:0]     digit_out,
    output logic                  frame_done
);

    localparam int c_MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int c_CW   = $clog2(c_MAXC) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BLANK = 2'd1;
    localparam logic [1:0] c_SHOW  = 2'd2;

    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK - 1);
    localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(DIV - 1);

    logic [1:0]          r_state, w_state_nxt;
    logic [1:0]          r_index, w_index_nxt;
    logic [c_CW-1:0]     r_cnt,   w_cnt_nxt;
    logic [4*DATA_W-1:0] r_shadow, w_shadow_nxt;
    logic                r_en, r_done, w_done_nxt;
    logic [DATA_W-1:0]   r_digit, w_digit_sel;

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_shadow_nxt = r_shadow;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (run) begin
                    w_shadow_nxt = digits;
                    w_index_nxt  = 2'd0;
                    w_state_nxt  = c_BLANK;
                end
            end
            c_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_SHOW;
                end
            end
            c_SHOW: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_index != 2'd3) begin
                        w_index_nxt = r_index + 2'd1;
                        w_state_nxt = c_BLANK;
                    end else begin
                        w_done_nxt  = 1'b1;
                        // index returns to 0 on both paths so IDLE drives a=b=0
                        w_index_nxt = 2'd0;
                        if (run) begin
                            w_shadow_nxt = digits;
                            w_state_nxt  = c_BLANK;
                        end else begin
                            w_state_nxt  = c_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_index_nxt = 2'd0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output registers are loaded from next-state values so they line up with the state
    always_comb begin
        w_digit_sel = '0;
        case (w_index_nxt)
            2'd0: w_digit_sel = w_shadow_nxt[0*DATA_W +: DATA_W];
            2'd1: w_digit_sel = w_shadow_nxt[1*DATA_W +: DATA_W];
            2'd2: w_digit_sel = w_shadow_nxt[2*DATA_W +: DATA_W];
            default: w_digit_sel = w_shadow_nxt[3*DATA_W +: DATA_W];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_index  <= 2'd0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_en     <= 1'b0;
            r_digit  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_index  <= w_index_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_en     <= (w_state_nxt == c_SHOW);
            r_digit  <= (w_state_nxt == c_SHOW) ? w_digit_sel : '0;
            r_done   <= w_done_nxt;
        end
    end

    assign a          = r_index[1];
    assign b          = r_index[0];
    assign en         = r_en;
    assign digit_out  = r_digit;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl4.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_ctrl4
// Brief    : Directed self-checking bench for scan_ctrl4 (default and DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_ctrl4;

    logic        clk = 1'b0;
    logic        rst, run, rst2, run2;
    logic [15:0] digits, digits2;
    logic        a, b, en, frame_done, a2, b2, en2, frame_done2;
    logic [3:0]  digit_out, digit_out2;
    logic [7:0]  obs1, obs2;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    scan_ctrl4 #(.DIV(4), .BLANK(1), .DATA_W(4)) u_dut (
        .clk(clk), .rst(rst), .run(run), .digits(digits),
        .a(a), .b(b), .en(en), .digit_out(digit_out), .frame_done(frame_done)
    );

    scan_ctrl4 #(.DIV(1), .BLANK(1), .DATA_W(4)) u_dut_edge (
        .clk(clk), .rst(rst2), .run(run2), .digits(digits2),
        .a(a2), .b(b2), .en(en2), .digit_out(digit_out2), .frame_done(frame_done2)
    );

    assign obs1 = {a, b, en, digit_out, frame_done};
    assign obs2 = {a2, b2, en2, digit_out2, frame_done2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {a,b,en,digit_out,frame_done} at position p of a frame (BLANK=1)
    function automatic logic [7:0] exp_vec(int p, logic [15:0] sh, int per, bit fd);
        int         d, s;
        logic [1:0] ab;
        logic [3:0] dig;
        d   = p / per;
        s   = p % per;
        ab  = d[1:0];
        dig = (s != 0) ? sh[d*4 +: 4] : 4'h0;
        return {ab, (s != 0), dig, fd};
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; digits = 16'h0000;
        tick(); tick();
        n_vec++; if (obs1 !== 8'h00) begin n_err++; $display("FAIL reset_outputs got %h exp 00", obs1); end
        n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b exp 0", en); end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (obs1 !== 8'h00) begin n_err++; $display("FAIL idle cyc=%0d got %h exp 00", k, obs1); end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] e;
        digits = 16'h4321; run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k <= 20) e = exp_vec(k - 1, 16'h4321, 5, 1'b0);
            else         e = {7'h00, (k == 21)};
            n_vec++;
            if (obs1 !== e) begin n_err++; $display("FAIL single_frame k=%0d got %h exp %h", k, obs1, e); end
            tick();
        end
    endtask

    task automatic test_continuous();
        logic [7:0]  e;
        logic [15:0] sh;
        logic [1:0]  prev_ab;
        int          en_cnt;
        en_cnt = 0;
        digits = 16'h4321; run = 1'b1;
        tick();
        prev_ab = 2'b00;
        for (int k = 1; k <= 62; k++) begin
            int p;
            p  = (k - 1) % 20;
            sh = (k <= 20) ? 16'h4321 : 16'h8765;
            if (k <= 60) e = exp_vec(p, sh, 5, (k > 1) && (p == 0));
            else         e = {7'h00, (k == 61)};
            n_vec++;
            if (obs1 !== e) begin n_err++; $display("FAIL continuous k=%0d got %h exp %h", k, obs1, e); end
            if ({a, b} !== prev_ab) begin
                n_vec++;
                if (en !== 1'b0) begin n_err++; $display("FAIL ab_change_en k=%0d got %b exp 0", k, en); end
            end
            prev_ab = {a, b};
            if (k <= 20 && en === 1'b1) en_cnt++;
            if (k == 7)  digits = 16'h8765;
            if (k == 41) run = 1'b0;
            tick();
        end
        n_vec++;
        if (en_cnt != 16) begin n_err++; $display("FAIL en_duty got %0d exp 16", en_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e;
        digits = 16'h4321; run = 1'b1;
        tick();
        for (int k = 1; k < 13; k++) tick();
        n_vec++;
        e = exp_vec(12, 16'h4321, 5, 1'b0);
        if (obs1 !== e) begin n_err++; $display("FAIL pre_reset got %h exp %h", obs1, e); end
        rst = 1'b1;
        tick();
        n_vec++;
        if (obs1 !== 8'h00) begin n_err++; $display("FAIL mid_reset got %h exp 00", obs1); end
        rst = 1'b0; digits = 16'hDCBA;
        tick();
        for (int k = 1; k <= 5; k++) begin
            e = exp_vec(k - 1, 16'hDCBA, 5, 1'b0);
            n_vec++;
            if (obs1 !== e) begin n_err++; $display("FAIL restart k=%0d got %h exp %h", k, obs1, e); end
            tick();
        end
        run = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_edge_params();
        logic [7:0] e;
        rst2 = 1'b0; digits2 = 16'hF0A5; run2 = 1'b1;
        n_vec++;
        if (obs2 !== 8'h00) begin n_err++; $display("FAIL edge_reset got %h exp 00", obs2); end
        tick();
        for (int k = 1; k <= 16; k++) begin
            e = exp_vec((k - 1) % 8, 16'hF0A5, 2, (k == 9));
            n_vec++;
            if (obs2 !== e) begin n_err++; $display("FAIL edge_params k=%0d got %h exp %h", k, obs2, e); end
            tick();
        end
        run2 = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1; run2 = 1'b0; digits2 = 16'h0000;
        test_reset();
        test_single_frame();
        test_continuous();
        test_mid_reset();
        test_edge_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
